// File: rtl/cc_ben_unit_pkg.sv
// Shared types, condition-code constants and the bus-to-NZP decode helper
// for the LC-3 condition-code / branch-enable unit.
// Pure declarations: no state, no timing.
package cc_pkg;

    typedef logic [2:0] nzp_t;

    localparam nzp_t NZP_N     = 3'b100;
    localparam nzp_t NZP_Z     = 3'b010;
    localparam nzp_t NZP_P     = 3'b001;
    localparam nzp_t NZP_RESET = NZP_Z;

    // Widest bus the decode helper accepts; callers zero-extend into it.
    localparam int CC_MAX_W = 64;

    // Decode a bus value of 'width' significant bits into a one-hot NZP.
    // Bits above 'width' must be zero, so the zero test can cover the whole
    // container and only the sign bit position depends on 'width'.
    function automatic nzp_t nzp_of(input logic [CC_MAX_W-1:0] bus, input int width);
        logic [CC_MAX_W-1:0] shifted;
        nzp_t                cc;
        shifted = bus >> (width - 1);
        if (shifted[0]) begin
            cc = NZP_N;
        end else if (bus == '0) begin
            cc = NZP_Z;
        end else begin
            cc = NZP_P;
        end
        return cc;
    endfunction

endpackage

// File: rtl/cc_ben_unit_if.sv
// Strobe and status bundle between the control FSM and the CC/BEN unit.
// No handshake: strobes are level-sampled at the rising clock edge.
// master = FSM/datapath side, slave = cc_ben_unit.
interface cc_ben_unit_if #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4
);
    import cc_pkg::*;

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [DATA_W-1:0]  bus;
    logic               ld_cc;
    logic [2:0]         ir_nzp;
    logic               ld_ben;
    logic               cc_push;
    logic               cc_pop;
    logic               err_clr;

    nzp_t               nzp;
    logic               ben;
    logic [DEPTH_W-1:0] depth;
    logic               stack_full;
    logic               stack_empty;
    logic               ovf_err;
    logic               unf_err;

    modport master (
        output bus, ld_cc, ir_nzp, ld_ben, cc_push, cc_pop, err_clr,
        input  nzp, ben, depth, stack_full, stack_empty, ovf_err, unf_err
    );

    modport slave (
        input  bus, ld_cc, ir_nzp, ld_ben, cc_push, cc_pop, err_clr,
        output nzp, ben, depth, stack_full, stack_empty, ovf_err, unf_err
    );

endinterface

// File: rtl/cc_ben_unit_stack.sv
// LIFO of saved NZP values used across interrupt entry / RTI.
// Push/pop take effect on the next edge; rdata is the current top, combinational.
// Illegal requests (push full, pop empty, push+pop together) are dropped and flagged.
module cc_stack
    import cc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  nzp_t               wdata_i,
    output nzp_t               rdata_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               pop_ok_o,
    output logic               ovf_o,
    output logic               unf_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    nzp_t               mem_q [DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic [DEPTH_W-1:0] depth_m1;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic               push_ok;

    assign full_o   = (depth_q == DEPTH_W'(DEPTH));
    assign empty_o  = (depth_q == '0);
    assign depth_o  = depth_q;

    // Simultaneous push and pop is treated as a conflict: neither happens.
    assign push_ok  = push_i && !pop_i && !full_o;
    assign pop_ok_o = pop_i && !push_i && !empty_o;
    assign ovf_o    = push_i && (full_o || pop_i);
    assign unf_o    = pop_i && (empty_o || push_i);

    assign depth_m1 = depth_q - DEPTH_W'(1);
    assign wr_idx   = depth_q[IDX_W-1:0];
    assign rd_idx   = depth_m1[IDX_W-1:0];
    assign rdata_o  = mem_q[rd_idx];

    // Depth moves by one on each accepted push or pop.
    always_comb begin
        depth_d = depth_q;
        if (push_ok) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop_ok_o) begin
            depth_d = depth_m1;
        end
    end

    // Occupancy counter, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry storage; contents after reset are irrelevant since depth is zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_idx] <= wdata_i;
        end
    end

endmodule

// File: rtl/cc_ben_unit.sv
// LC-3 condition-code register, branch-enable register and saved-NZP stack.
// All state updates 1 cycle after the strobe; stack_full/empty decode depth directly.
// No backpressure: illegal stack requests are dropped and raise sticky error flags.
module cc_ben_unit
    import cc_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter bit NOP_ZERO    = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    cc_ben_unit_if.slave    io
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    nzp_t               nzp_q;
    nzp_t               nzp_d;
    logic               ben_q;
    logic               ben_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               unf_q;
    logic               unf_d;

    nzp_t               bus_cc;
    logic [2:0]         mask;
    nzp_t               stk_top;
    logic [DEPTH_W-1:0] stk_depth;
    logic               stk_full;
    logic               stk_empty;
    logic               pop_ok;
    logic               ovf_evt;
    logic               unf_evt;

    // The stack always saves the pre-edge NZP, so a push with ld_cc keeps the old value.
    cc_stack #(
        .DEPTH   (STACK_DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_stack (
        .clk      (clk),
        .rst      (reset),
        .push_i   (io.cc_push),
        .pop_i    (io.cc_pop),
        .wdata_i  (nzp_q),
        .rdata_o  (stk_top),
        .depth_o  (stk_depth),
        .full_o   (stk_full),
        .empty_o  (stk_empty),
        .pop_ok_o (pop_ok),
        .ovf_o    (ovf_evt),
        .unf_o    (unf_evt)
    );

    assign bus_cc = nzp_of(CC_MAX_W'(io.bus), DATA_W);

    // With NOP_ZERO clear, an all-zero condition field means "branch always".
    assign mask = (!NOP_ZERO && (io.ir_nzp == 3'b000)) ? 3'b111 : io.ir_nzp;

    // Next-state: restored NZP beats a bus load; ben tests the pre-edge NZP;
    // an error event in the same cycle as err_clr keeps its flag set.
    always_comb begin
        nzp_d = nzp_q;
        if (pop_ok) begin
            nzp_d = stk_top;
        end else if (io.ld_cc) begin
            nzp_d = bus_cc;
        end

        ben_d = ben_q;
        if (io.ld_ben) begin
            ben_d = |(nzp_q & mask);
        end

        ovf_d = ovf_q;
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (io.err_clr) begin
            ovf_d = 1'b0;
        end

        unf_d = unf_q;
        if (unf_evt) begin
            unf_d = 1'b1;
        end else if (io.err_clr) begin
            unf_d = 1'b0;
        end
    end

    // Architectural registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nzp_q <= NZP_RESET;
            ben_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            nzp_q <= nzp_d;
            ben_q <= ben_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign io.nzp         = nzp_q;
    assign io.ben         = ben_q;
    assign io.depth       = stk_depth;
    assign io.stack_full  = stk_full;
    assign io.stack_empty = stk_empty;
    assign io.ovf_err     = ovf_q;
    assign io.unf_err     = unf_q;

endmodule

// File: tb/tb_cc_ben_unit.sv
// Self-checking bench for cc_ben_unit: directed scenarios plus a randomized run
// against a queue-based reference model of the condition-code rules.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_cc_ben_unit;
    import cc_pkg::*;

    localparam int DW   = 16;
    localparam int SD   = 4;
    localparam bit NZ   = 1'b1;
    localparam int DEPW = $clog2(SD + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cc_ben_unit_if #(.DATA_W(DW), .STACK_DEPTH(SD)) io ();

    cc_ben_unit #(.DATA_W(DW), .STACK_DEPTH(SD), .NOP_ZERO(NZ)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [2:0] m_nzp;
    logic       m_ben;
    logic       m_ovf;
    logic       m_unf;
    logic [2:0] m_stk [$];

    function automatic logic [2:0] ref_cc(input logic [DW-1:0] b);
        if ($signed(b) < 0) return 3'b100;
        if (b == 0)         return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_reset();
        m_nzp = 3'b010;
        m_ben = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_step(input logic [DW-1:0] b, input logic lcc, input logic [2:0] ir,
                              input logic lben, input logic push, input logic pop, input logic clr);
        logic [2:0] old_nzp;
        logic [2:0] msk;
        logic       oe;
        logic       ue;
        old_nzp = m_nzp;
        oe = push && (pop || m_stk.size() == SD);
        ue = pop && (push || m_stk.size() == 0);
        msk = (!NZ && ir == 3'b000) ? 3'b111 : ir;
        if (lben) m_ben = ((old_nzp & msk) != 0);
        if (pop && !push && m_stk.size() > 0) m_nzp = m_stk.pop_back();
        else if (lcc)                        m_nzp = ref_cc(b);
        if (push && !pop && m_stk.size() < SD) m_stk.push_back(old_nzp);
        if (oe) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (ue) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    endtask

    task automatic idle_inputs();
        io.bus     = '0;
        io.ld_cc   = 1'b0;
        io.ir_nzp  = 3'b000;
        io.ld_ben  = 1'b0;
        io.cc_push = 1'b0;
        io.cc_pop  = 1'b0;
        io.err_clr = 1'b0;
    endtask

    // Drive one cycle of strobes, advance the model, land on the next falling edge.
    task automatic apply(input logic [DW-1:0] b, input logic lcc, input logic [2:0] ir,
                         input logic lben, input logic push, input logic pop, input logic clr);
        io.bus     = b;
        io.ld_cc   = lcc;
        io.ir_nzp  = ir;
        io.ld_ben  = lben;
        io.cc_push = push;
        io.cc_pop  = pop;
        io.err_clr = clr;
        model_step(b, lcc, ir, lben, push, pop, clr);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (io.nzp !== 3'b010 || io.ben !== 1'b0 || io.depth !== DEPW'(0)) begin
            miscompares++;
            $display("FAIL reset_regs: nzp=%b ben=%b depth=%0d, expected 010 0 0", io.nzp, io.ben, io.depth);
        end
        vectors++;
        if (io.stack_empty !== 1'b1 || io.stack_full !== 1'b0 || io.ovf_err !== 1'b0 || io.unf_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: empty=%b full=%b ovf=%b unf=%b, expected 1 0 0 0",
                     io.stack_empty, io.stack_full, io.ovf_err, io.unf_err);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cc_derive();
        logic [DW-1:0] buses [3];
        logic [2:0]    exp   [3];
        buses[0] = 16'h8000; exp[0] = 3'b100;
        buses[1] = 16'h0000; exp[1] = 3'b010;
        buses[2] = 16'h0001; exp[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            apply(buses[i], 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (io.nzp !== exp[i]) begin
                miscompares++;
                $display("FAIL cc_derive[%0d]: bus=%h nzp=%b expected %b", i, buses[i], io.nzp, exp[i]);
            end
        end
    endtask

    task automatic test_ben();
        logic [2:0] irs [3];
        logic       exp [3];
        irs[0] = 3'b010; exp[0] = 1'b1;
        irs[1] = 3'b101; exp[1] = 1'b0;
        irs[2] = 3'b000; exp[2] = NZ ? 1'b0 : 1'b1;
        apply(16'h0000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(16'h0000, 1'b0, irs[i], 1'b1, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (io.ben !== exp[i]) begin
                miscompares++;
                $display("FAIL ben[%0d]: ir_nzp=%b ben=%b expected %b", i, irs[i], io.ben, exp[i]);
            end
        end
        // ben holds when ld_ben is low
        apply(16'h8000, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (io.ben !== exp[2]) begin
            miscompares++;
            $display("FAIL ben_hold: ben=%b expected %b", io.ben, exp[2]);
        end
    endtask

    task automatic test_stack();
        logic [2:0] pops [4];
        pops[0] = 3'b100; pops[1] = 3'b001; pops[2] = 3'b010; pops[3] = 3'b100;
        apply(16'h8000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        apply(16'h0000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);   // push 100
        apply(16'h0001, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);   // push 010
        apply(16'h8000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);   // push 001
        apply(16'h0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);   // push 100
        vectors++;
        if (io.depth !== DEPW'(4) || io.stack_full !== 1'b1 || io.ovf_err !== 1'b0) begin
            miscompares++;
            $display("FAIL stack_fill: depth=%0d full=%b ovf=%b expected 4 1 0", io.depth, io.stack_full, io.ovf_err);
        end
        apply(16'h0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);   // overflow
        vectors++;
        if (io.depth !== DEPW'(4) || io.ovf_err !== 1'b1) begin
            miscompares++;
            $display("FAIL stack_ovf: depth=%0d ovf=%b expected 4 1", io.depth, io.ovf_err);
        end
        for (int i = 0; i < 4; i++) begin
            apply(16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
            vectors++;
            if (io.nzp !== pops[i] || io.depth !== DEPW'(3 - i)) begin
                miscompares++;
                $display("FAIL stack_pop[%0d]: nzp=%b depth=%0d expected %b %0d", i, io.nzp, io.depth, pops[i], 3 - i);
            end
        end
        vectors++;
        if (io.stack_empty !== 1'b1 || io.unf_err !== 1'b0) begin
            miscompares++;
            $display("FAIL stack_drained: empty=%b unf=%b expected 1 0", io.stack_empty, io.unf_err);
        end
        apply(16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_underflow();
        apply(16'h0005, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (io.unf_err !== 1'b1 || io.nzp !== 3'b001 || io.depth !== DEPW'(0)) begin
            miscompares++;
            $display("FAIL unf_ldcc: unf=%b nzp=%b depth=%0d expected 1 001 0", io.unf_err, io.nzp, io.depth);
        end
        apply(16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);  // error wins over clear
        vectors++;
        if (io.unf_err !== 1'b1) begin
            miscompares++;
            $display("FAIL unf_clr_race: unf=%b expected 1", io.unf_err);
        end
        apply(16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (io.unf_err !== 1'b0) begin
            miscompares++;
            $display("FAIL unf_clr: unf=%b expected 0", io.unf_err);
        end
    endtask

    task automatic test_push_ld();
        apply(16'h0001, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(16'h0000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (io.nzp !== 3'b010 || io.depth !== DEPW'(1)) begin
            miscompares++;
            $display("FAIL push_ldcc: nzp=%b depth=%0d expected 010 1", io.nzp, io.depth);
        end
        // pop with ld_cc plus ld_ben: popped value wins, ben tests pre-edge 010
        apply(16'h8000, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (io.nzp !== 3'b001 || io.ben !== 1'b1 || io.depth !== DEPW'(0)) begin
            miscompares++;
            $display("FAIL pop_ldcc: nzp=%b ben=%b depth=%0d expected 001 1 0", io.nzp, io.ben, io.depth);
        end
        // push and pop together: both dropped, both flags set, ld_cc honoured
        apply(16'h8000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (io.nzp !== 3'b100 || io.depth !== DEPW'(0) || io.ovf_err !== 1'b1 || io.unf_err !== 1'b1) begin
            miscompares++;
            $display("FAIL push_pop: nzp=%b depth=%0d ovf=%b unf=%b expected 100 0 1 1",
                     io.nzp, io.depth, io.ovf_err, io.unf_err);
        end
        apply(16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        apply(16'h0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(16'h0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(16'h0000, 1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (io.depth !== DEPW'(2) || io.ben !== 1'b1 || io.ovf_err !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_setup: depth=%0d ben=%b ovf=%b expected 2 1 1", io.depth, io.ben, io.ovf_err);
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (io.nzp !== 3'b010 || io.ben !== 1'b0 || io.depth !== DEPW'(0) || io.ovf_err !== 1'b0 ||
            io.unf_err !== 1'b0 || io.stack_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL areset: nzp=%b ben=%b depth=%0d ovf=%b unf=%b empty=%b expected 010 0 0 0 0 1",
                     io.nzp, io.ben, io.depth, io.ovf_err, io.unf_err, io.stack_empty);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [DW-1:0] b;
        logic [1:0]    sel;
        for (int i = 0; i < 400; i++) begin
            sel = 2'($urandom_range(0, 3));
            b = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h8000 : DW'($urandom);
            apply(b, ($urandom_range(0, 1) == 1), 3'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            vectors++;
            if (io.nzp !== m_nzp || !$onehot(io.nzp) || io.ben !== m_ben) begin
                miscompares++;
                $display("FAIL rand_cc[%0d]: nzp=%b ben=%b expected %b %b", i, io.nzp, io.ben, m_nzp, m_ben);
            end
            vectors++;
            if (io.depth !== DEPW'(m_stk.size()) || io.stack_full !== (m_stk.size() == SD) ||
                io.stack_empty !== (m_stk.size() == 0)) begin
                miscompares++;
                $display("FAIL rand_stack[%0d]: depth=%0d full=%b empty=%b expected depth %0d",
                         i, io.depth, io.stack_full, io.stack_empty, m_stk.size());
            end
            vectors++;
            if (io.ovf_err !== m_ovf || io.unf_err !== m_unf) begin
                miscompares++;
                $display("FAIL rand_err[%0d]: ovf=%b unf=%b expected %b %b", i, io.ovf_err, io.unf_err, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cc_derive();
        test_ben();
        test_stack();
        test_underflow();
        test_push_ld();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cc_ben_unit.md
# cc_ben_unit

Condition-code and branch-enable unit for the LC-3 datapath. It derives the N/Z/P condition codes from the CPU bus and holds them in a register. It evaluates BR instructions into a registered branch-enable bit. It also keeps a LIFO of saved condition codes so interrupt entry and RTI can save and restore NZP without touching memory. The FSM drives its load, push and pop strobes, and its `nzp` output feeds the PSR view and the next-state logic.

## Interface
Parameters:
- `DATA_W`, 16: bus width used for CC derivation (≥2).
- `STACK_DEPTH`, 4: number of saved-NZP entries (≥1).
- `NOP_ZERO`, 1: 1 = `ir_nzp`=000 never branches (LC-3 NOP); 0 = 000 is treated as 111 (unconditional).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `bus` in DATA_W: value being written to a GPR.
- `ld_cc` in 1: load NZP from `bus`.
- `ir_nzp` in 3: IR[11:9] branch condition mask.
- `ld_ben` in 1: load `ben`.
- `cc_push` in 1: save the current NZP onto the stack.
- `cc_pop` in 1: restore NZP from the top of the stack.
- `err_clr` in 1: clear the sticky error flags.
- `nzp` out 3: registered condition codes, [2]=N, [1]=Z, [0]=P.
- `ben` out 1: registered branch enable.
- `depth` out $clog2(STACK_DEPTH+1): number of valid stack entries.
- `stack_full` out 1: `depth`==STACK_DEPTH.
- `stack_empty` out 1: `depth`==0.
- `ovf_err` out 1: sticky; set by a push when full.
- `unf_err` out 1: sticky; set by a pop when empty.

## Operation
- **Reset values:** `nzp`=3'b010; `ben`=0; `depth`=0; `ovf_err`=0; `unf_err`=0. Stack contents are don't-care.
- **CC derivation** (the value `ld_cc` loads):
  - `bus`[DATA_W-1]=1 gives 100.
  - `bus`==0 gives 010.
  - Otherwise 001.
  - Exactly one bit of `nzp` is ever set.
- **Branch enable:**
  - On `ld_ben`, `ben` <= |(`nzp` & mask).
  - mask = `ir_nzp`, except when NOP_ZERO=0 and `ir_nzp`==000, where mask = 111.
  - Without `ld_ben`, `ben` holds.
- **Push** (not full, no pop): writes the pre-update `nzp` at index `depth`; `depth`+1.
- **Pop** (not empty, no push): `nzp` <= entry at `depth`-1; `depth`-1.
- **Next-`nzp` priority:** successful pop > `ld_cc` > hold.
- **Boundary and simultaneous events:**
  - Push when full: stack and `depth` unchanged; `ovf_err` set; `ld_cc` still honoured.
  - Pop when empty: `nzp` unchanged by the pop; `unf_err` set; `ld_cc` still honoured.
  - `cc_push` and `cc_pop` together: both ignored, stack unchanged, `ovf_err` and `unf_err` both set. `ld_cc` is honoured.
  - `cc_push` with `ld_cc`: the old NZP is pushed and the new NZP is loaded in the same edge.
  - `cc_pop` with `ld_cc`, pop successful: the popped value wins and `ld_cc` is dropped.
  - `ld_ben` with `ld_cc` or pop: `ben` uses the pre-edge `nzp`.
  - `err_clr` clears both flags; an error event in the same cycle wins (flag stays set).
- **Reset asserted mid-operation** immediately forces all reset values.

## Timing
- Every output is registered except `stack_full` and `stack_empty`, which decode `depth` combinationally.
- Latency:
  - `ld_cc` → `nzp`: 1 cycle.
  - `ld_ben` → `ben`: 1 cycle.
  - Push/pop → `depth` and `nzp`: 1 cycle.
- Back-to-back push/pop every cycle is legal. There is no handshake; strobes are single-cycle, level-sampled at the edge.
- A CC load followed by a branch test needs `ld_ben` at least 1 cycle after `ld_cc`; the LC-3 FSM already spaces them this way.

## Structure
- **Package `cc_pkg`:**
  - `typedef logic [2:0] nzp_t`.
  - Constants `NZP_N`=100, `NZP_Z`=010, `NZP_P`=001, `NZP_RESET`=`NZP_Z`.
  - Function `nzp_of(bus)`, parametrised by width via a generic port of DATA_W.
- **Sub-module `cc_stack`:**
  - LIFO of `nzp_t` with push, pop, wdata, rdata, depth, full, empty.
  - Rejects illegal operations and reports them.
- **Top level:** the NZP register, `ben` register, priority logic and sticky flags.

## Test plan
1. Reset, then `ld_cc` with `bus`=16'h8000, 16'h0000 and 16'h0001 on successive cycles → `nzp` = 100, 010, 001, each one cycle later.
2. `nzp`=010; `ld_ben` with `ir_nzp`=010 → `ben`=1. Then with `ir_nzp`=101 → `ben`=0. Then with `ir_nzp`=000 → `ben`=0 (NOP_ZERO=1) or `ben`=1 (NOP_ZERO=0 build).
3. Push 100, 010, 001, 100 → `depth`=4, `stack_full`=1. A fifth push → `ovf_err`=1, `depth`=4. Four pops → `nzp` = 100, 001, 010, 100 in order, `stack_empty`=1.
4. Pop on empty with `ld_cc`, `bus`=16'h0005 → `unf_err`=1, `nzp`=001. Then `err_clr` → `unf_err`=0 one cycle later.
5. `nzp`=001; `cc_push` and `ld_cc` (`bus`=0) in the same cycle → `nzp`=010. A later pop → `nzp`=001.
6. Assert `reset` asynchronously with `depth`=2, `ben`=1 and `ovf_err`=1 → all outputs return to reset values without waiting for a clock edge.
